seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive-side counterpart of the seven-segment driver. It watches the
//  active-low seg_a..seg_g and an_0..an_7 lines of a multiplexed display and
//  recovers the hex digit shown on each anode into an 8-nibble register bank.
//  Used as an on-chip loopback monitor for display logic and in benches as a
//  self-checking scoreboard.
// PARAMETERS
//  SETTLE_CYCLES  4  consecutive identical input cycles required before capture (>=1)
//  ACTIVE_LOW     1  1: seg/an lines are asserted low; 0: asserted high
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   synchronous reset, active-high
//  seg_a..seg_g in   1   segment lines under observation (7 ports)
//  an_0..an_7   in   1   anode enables under observation (8 ports)
//  digits       out  32  recovered digits; digit k = digits[4k+3:4k]
//  digit_valid  out  8   bit k = digit k holds a decoded, non-blank value
//  frame_done   out  1   one-cycle pulse: all 8 anodes captured since the last pulse
//  pattern_err  out  1   one-cycle pulse: settled pattern is not a legal glyph
//  multi_an_err out  1   one-cycle pulse: more than one anode asserted (registered)
// BEHAVIOUR
//  - Clocking/reset: one clock. rst is synchronous and active-high. On reset,
//    all outputs are 0, state is IDLE, the settle counter is 0, and the seen mask is 0.
//  - Input stage: one register stage normalises polarity (ACTIVE_LOW inverts)
//    into an[7:0] and seg[6:0] = {a,b,c,d,e,f,g}, 1 = lit.
//  - Anode qualification (registered value):
//    - no bit set: blank interval, go to IDLE;
//    - more than one bit set: multi_an_err pulses for 1 cycle, go to IDLE, nothing captured;
//    - exactly one bit set: index k is the candidate.
//  - FSM states IDLE, SETTLING, CAPTURED:
//    - IDLE -> SETTLING on a one-hot anode; cnt = 1; key {k,seg} latched.
//    - SETTLING: if key is unchanged, cnt++; when cnt == SETTLE_CYCLES, capture and
//      go to CAPTURED. If key changes, restart SETTLING (cnt = 1, new key), or go
//      to IDLE if the anode is no longer one-hot.
//    - CAPTURED: hold, with no further captures, until the key changes; then go to
//      SETTLING or IDLE as above. This gives exactly one capture per dwell.
//  - Latency: outputs update on the (SETTLE_CYCLES+1)th rising edge after the
//    inputs become stable (1 input register plus SETTLE_CYCLES).
//  - Capture (single cycle, into digit k):
//    - legal glyph: digits[k] = value, digit_valid[k] = 1;
//    - seg = 0000000: digit_valid[k] = 0, digits[k] unchanged, no error;
//    - any other pattern: pattern_err pulse, digit_valid[k] = 0, digits[k] unchanged.
//    - Every capture sets seen[k].
//  - Glyph table (abcdefg):
//    - 0=1111110 1=0110000 2=1101101 3=1111001
//    - 4=0110011 5=1011011 6=1011111 7=1110000
//    - 8=1111111 9=1111011 A=1110111 b=0011111
//    - C=1001110 d=0111101 E=1001111 F=1000111
//  - Frame tracking:
//    - When the capture makes seen == 8'hFF: frame_done pulses on the same edge as
//      the output update, and seen clears to 0 on that edge.
//    - Captures of a digit already in seen overwrite the data and do not re-count.
//  - Reset asserted mid-dwell aborts the dwell: no capture, and all state follows
//    the reset values above.
// STRUCTURE
//  - seg7_pkg holds:
//    - glyph localparams SEG_0..SEG_F (7-bit abcdefg);
//    - typedef enum logic [1:0] {IDLE, SETTLING, CAPTURED} scan_state_t;
//    - NUM_DIGITS = 8.
//  - Sub-module seg7_glyph_decode: combinational seg[6:0] -> {legal, blank,
//    value[3:0]}. It is the exact inverse of the team's encoder table.
//  - Top level: input register, one-hot check/encoder, settle counter plus FSM,
//    digit bank, seen mask.
// TESTING (ACTIVE_LOW=1, SETTLE_CYCLES=4)
//  1. Hold an_2 low and seg = glyph 5 for 5 cycles
//     -> on the 5th edge digits[11:8]=4'h5 and digit_valid=8'h04; no error pulses.
//  2. Scan anodes 0..7 with glyphs 0..7, 6 cycles each
//     -> digits=32'h7654_3210, digit_valid=8'hFF, and exactly one frame_done
//        pulse, on the digit-7 capture.
//  3. Hold an_1 with seg=1111111 (abcdefg; all segments off, active-low) for 8 cycles
//     -> no error, digit_valid[1]=0, digits[7:4] unchanged.
//  4. Assert an_0 and an_3 together
//     -> multi_an_err pulses once, and no digit or valid bit changes.
//  5. Hold an_4 with seg=0101010 (abcdefg, active-low; lit pattern not in the table)
//     -> pattern_err pulses once, digit_valid[4]=0.
//     Then toggle the segments every 3 cycles -> no capture occurs.
//  6. Pulse rst on the 3rd cycle of a dwell
//     -> no capture, all outputs 0 on the next edge, and the next dwell captures normally.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan decoder: glyph encodings
// (abcdefg, 1 = lit), scan FSM states and digit count.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  typedef enum logic [1:0] {IDLE, SETTLING, CAPTURED} scan_state_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of the hex glyph encoder: seg (abcdefg, 1 = lit) ->
// legal glyph flag, all-dark flag and the hex value.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] value
);

  always_comb begin
    legal = 1'b1;
    blank = 1'b0;
    value = 4'h0;
    case (seg)
      SEG_0:   value = 4'h0;
      SEG_1:   value = 4'h1;
      SEG_2:   value = 4'h2;
      SEG_3:   value = 4'h3;
      SEG_4:   value = 4'h4;
      SEG_5:   value = 4'h5;
      SEG_6:   value = 4'h6;
      SEG_7:   value = 4'h7;
      SEG_8:   value = 4'h8;
      SEG_9:   value = 4'h9;
      SEG_A:   value = 4'hA;
      SEG_B:   value = 4'hB;
      SEG_C:   value = 4'hC;
      SEG_D:   value = 4'hD;
      SEG_E:   value = 4'hE;
      SEG_F:   value = 4'hF;
      7'b0000000: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a multiplexed 7-segment display and recovers the digit shown on each
// anode; one capture per dwell once the {anode, segments} key has been stable.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seg_a,
  input  logic        seg_b,
  input  logic        seg_c,
  input  logic        seg_d,
  input  logic        seg_e,
  input  logic        seg_f,
  input  logic        seg_g,
  input  logic        an_0,
  input  logic        an_1,
  input  logic        an_2,
  input  logic        an_3,
  input  logic        an_4,
  input  logic        an_5,
  input  logic        an_6,
  input  logic        an_7,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        pattern_err,
  output logic        multi_an_err
);

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

  logic [7:0]  raw_an;
  logic [6:0]  raw_seg;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [2:0]  idx;
  logic        onehot;
  logic        multi;
  logic [2:0]  key_idx;
  logic [6:0]  key_seg;
  logic [CW-1:0] cnt;
  scan_state_t state;
  logic        same_key;
  logic        start;
  logic        capture;
  logic [7:0]  seen;
  logic [7:0]  seen_next;
  logic        legal;
  logic        blank;
  logic [3:0]  value;

  assign raw_an  = {an_7, an_6, an_5, an_4, an_3, an_2, an_1, an_0};
  assign raw_seg = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};

  // Input stage: normalise to 1 = asserted, and break the path from the pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '0;
      seg <= '0;
    end else begin
      an  <= ACTIVE_LOW ? ~raw_an  : raw_an;
      seg <= ACTIVE_LOW ? ~raw_seg : raw_seg;
    end
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an[i]) idx = 3'(i);
    end
  end

  assign onehot   = (an != 8'h00) && ((an & (an - 8'd1)) == 8'h00);
  assign multi    = (an != 8'h00) && !onehot;
  assign same_key = onehot && (idx == key_idx) && (seg == key_seg);
  assign start    = onehot && ((state == IDLE) || !same_key);
  // A one-cycle settle window captures on the very first cycle of a dwell.
  assign capture  = (start && (SETTLE_CYCLES == 1)) ||
                    ((state == SETTLING) && same_key && (cnt == CW'(SETTLE_CYCLES - 1)));
  assign seen_next = seen | (8'b1 << idx);

  seg7_glyph_decode u_decode (
    .seg   (seg),
    .legal (legal),
    .blank (blank),
    .value (value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      key_idx <= '0;
      key_seg <= '0;
    end else if (!onehot) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (start) begin
      key_idx <= idx;
      key_seg <= seg;
      cnt     <= CW'(1);
      state   <= (SETTLE_CYCLES == 1) ? CAPTURED : SETTLING;
    end else if (state == SETTLING) begin
      cnt <= cnt + 1'b1;
      if (capture) state <= CAPTURED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits       <= '0;
      digit_valid  <= '0;
      seen         <= '0;
      frame_done   <= 1'b0;
      pattern_err  <= 1'b0;
      multi_an_err <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      pattern_err  <= 1'b0;
      multi_an_err <= multi;
      if (capture) begin
        if (legal) begin
          digits[{idx, 2'b00} +: 4] <= value;
          digit_valid[idx]          <= 1'b1;
        end else begin
          digit_valid[idx] <= 1'b0;
          pattern_err      <= !blank;
        end
        if (seen_next == 8'hFF) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed and randomized bench for seg7_scan_decoder against a run-length
// reference model of the display (ACTIVE_LOW=1, SETTLE_CYCLES=4).
module tb_seg7_scan_decoder;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_pin = 7'h7F;
  logic [7:0]  an_pin  = 8'hFF;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        frame_done, pattern_err, multi_an_err;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.SETTLE_CYCLES(SETTLE), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst),
    .seg_a(seg_pin[6]), .seg_b(seg_pin[5]), .seg_c(seg_pin[4]), .seg_d(seg_pin[3]),
    .seg_e(seg_pin[2]), .seg_f(seg_pin[1]), .seg_g(seg_pin[0]),
    .an_0(an_pin[0]), .an_1(an_pin[1]), .an_2(an_pin[2]), .an_3(an_pin[3]),
    .an_4(an_pin[4]), .an_5(an_pin[5]), .an_6(an_pin[6]), .an_7(an_pin[7]),
    .digits(digits), .digit_valid(digit_valid), .frame_done(frame_done),
    .pattern_err(pattern_err), .multi_an_err(multi_an_err)
  );

  logic [6:0] glyph_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int checks = 0;
  int errors = 0;

  // Reference model: a digit is captured when the registered one-hot
  // {anode, segments} pair has been seen for exactly SETTLE consecutive cycles.
  logic [7:0]  m_an_r  = '0;
  logic [6:0]  m_seg_r = '0;
  logic [7:0]  p_an    = '0;
  logic [6:0]  p_seg   = '0;
  int          run     = 0;
  logic [31:0] e_digits = '0;
  logic [7:0]  e_valid  = '0;
  logic [7:0]  e_seen   = '0;
  logic        e_frame = 1'b0, e_perr = 1'b0, e_multi = 1'b0;
  int          fd_cnt = 0, pe_cnt = 0, me_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [7:0] an_lit, input logic [6:0] seg_lit);
    int   k;
    logic found;
    logic [3:0] v;
    if (r) begin
      e_digits = '0; e_valid = '0; e_seen = '0;
      e_frame = 0; e_perr = 0; e_multi = 0;
      run = 0; p_an = '0; p_seg = '0;
      m_an_r = '0; m_seg_r = '0;
      return;
    end
    e_frame = 0;
    e_perr  = 0;
    e_multi = ($countones(m_an_r) > 1);
    if ($countones(m_an_r) == 1) begin
      if (run > 0 && m_an_r == p_an && m_seg_r == p_seg) run++;
      else run = 1;
    end else begin
      run = 0;
    end
    p_an  = m_an_r;
    p_seg = m_seg_r;
    if (run == SETTLE) begin
      k = 0;
      for (int i = 0; i < 8; i++) if (m_an_r[i]) k = i;
      found = 0;
      v = '0;
      for (int i = 0; i < 16; i++) if (glyph_tbl[i] == m_seg_r) begin found = 1; v = 4'(i); end
      if (found) begin
        e_digits[k*4 +: 4] = v;
        e_valid[k] = 1'b1;
      end else begin
        e_valid[k] = 1'b0;
        e_perr = (m_seg_r != 7'h00);
      end
      e_seen[k] = 1'b1;
      if (e_seen == 8'hFF) begin
        e_frame = 1;
        e_seen  = '0;
      end
    end
    m_an_r  = an_lit;
    m_seg_r = seg_lit;
  endtask

  // One clock: drive pins (active-low), advance model, check all outputs.
  task automatic step(input logic r, input logic [7:0] an_lit, input logic [6:0] seg_lit);
    rst     = r;
    an_pin  = ~an_lit;
    seg_pin = ~seg_lit;
    @(posedge clk);
    model_edge(r, an_lit, seg_lit);
    #1;
    fd_cnt += int'(frame_done);
    pe_cnt += int'(pattern_err);
    me_cnt += int'(multi_an_err);
    chk("digits", digits, e_digits);
    chk("digit_valid", {24'h0, digit_valid}, {24'h0, e_valid});
    chk("frame_done", {31'h0, frame_done}, {31'h0, e_frame});
    chk("pattern_err", {31'h0, pattern_err}, {31'h0, e_perr});
    chk("multi_an_err", {31'h0, multi_an_err}, {31'h0, e_multi});
  endtask

  task automatic dwell(input int n, input logic [7:0] an_lit, input logic [6:0] seg_lit);
    for (int i = 0; i < n; i++) step(1'b0, an_lit, seg_lit);
  endtask

  initial begin
    logic [31:0] snap_d;
    logic [7:0]  snap_v;
    logic [7:0]  ra;
    logic [6:0]  rs;
    int          sel, len;

    step(1'b1, 8'h00, 7'h00);
    step(1'b1, 8'h00, 7'h00);
    chk("reset_digits", digits, 32'h0);
    chk("reset_valid", {24'h0, digit_valid}, 32'h0);

    // 1: single dwell, capture on the 5th edge
    dwell(4, 8'h04, glyph_tbl[5]);
    chk("t1_latency_valid", {24'h0, digit_valid}, 32'h0);
    dwell(1, 8'h04, glyph_tbl[5]);
    chk("t1_digit2", {28'h0, digits[11:8]}, 32'h5);
    chk("t1_valid", {24'h0, digit_valid}, 32'h04);

    // 2: full scan
    fd_cnt = 0;
    for (int d = 0; d < 8; d++) dwell(6, 8'(1 << d), glyph_tbl[d]);
    chk("t2_digits", digits, 32'h7654_3210);
    chk("t2_valid", {24'h0, digit_valid}, 32'hFF);
    chk("t2_frame_count", fd_cnt, 1);

    // 3: blank dwell clears valid, keeps data, no error
    pe_cnt = 0;
    dwell(8, 8'h02, 7'h00);
    chk("t3_valid1", {31'h0, digit_valid[1]}, 32'h0);
    chk("t3_digit1", {28'h0, digits[7:4]}, 32'h1);
    chk("t3_perr", pe_cnt, 0);

    // 4: two anodes at once
    me_cnt = 0;
    snap_d = digits;
    snap_v = digit_valid;
    dwell(1, 8'h09, glyph_tbl[8]);
    dwell(3, 8'h00, 7'h00);
    chk("t4_multi_count", me_cnt, 1);
    chk("t4_digits", digits, snap_d);
    chk("t4_valid", {24'h0, digit_valid}, {24'h0, snap_v});

    // 5: illegal glyph, then a pattern that never settles
    pe_cnt = 0;
    dwell(6, 8'h10, 7'b1010101);
    chk("t5_perr_count", pe_cnt, 1);
    chk("t5_valid4", {31'h0, digit_valid[4]}, 32'h0);
    snap_d = digits;
    snap_v = digit_valid;
    pe_cnt = 0;
    for (int t = 0; t < 6; t++) dwell(3, 8'h10, (t % 2 == 0) ? glyph_tbl[3] : glyph_tbl[6]);
    chk("t5_toggle_digits", digits, snap_d);
    chk("t5_toggle_valid", {24'h0, digit_valid}, {24'h0, snap_v});

    // 6: reset mid-dwell
    dwell(2, 8'h20, glyph_tbl[9]);
    step(1'b1, 8'h20, glyph_tbl[9]);
    chk("t6_reset_digits", digits, 32'h0);
    chk("t6_reset_valid", {24'h0, digit_valid}, 32'h0);
    dwell(5, 8'h20, glyph_tbl[9]);
    chk("t6_digit5", {28'h0, digits[23:20]}, 32'h9);
    chk("t6_valid", {24'h0, digit_valid}, 32'h20);

    // Random dwells
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 8);
      if (sel < 8) ra = 8'(1 << sel);
      else if (sel == 8) ra = 8'h00;
      else begin
        ra  = 8'(1 << $urandom_range(0, 3)) | 8'(1 << $urandom_range(4, 7));
        len = 1;
      end
      sel = $urandom_range(0, 9);
      if (sel < 7) rs = glyph_tbl[$urandom_range(0, 15)];
      else if (sel == 7) rs = 7'h00;
      else rs = 7'($urandom);
      dwell(len, ra, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
